// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;
    localparam int NUM_SRC  = 2;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order writeback FIFO; exposes the addresses of its valid entries
// so the top level can detect pending writes to a decode read address.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [DEPTH*AW-1:0]        valid_addrs
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Slots outside the occupied window report address 0, which never matches a pend query.
    always_comb begin
        logic [PW-1:0] off;
        valid_addrs = '0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (CW'(off) < count) begin
                valid_addrs[i*AW +: AW] = addr_mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between the ALU (s0)
// and load unit (s1), with pending-write flags for decode stall logic.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_addr,
    input  logic [DW-1:0] s0_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_addr,
    input  logic [DW-1:0] s1_data,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          pend1,
    output logic          pend2,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic          idle
);

    localparam int CW = $clog2(DEPTH+1);

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] grant;
    logic [CW-1:0]      count0;
    logic [CW-1:0]      count1;
    logic [AW-1:0]      head_addr0;
    logic [AW-1:0]      head_addr1;
    logic [DW-1:0]      head_data0;
    logic [DW-1:0]      head_data1;
    logic [DEPTH*AW-1:0] valid_addrs0;
    logic [DEPTH*AW-1:0] valid_addrs1;
    logic               last_grant;

    assign s0_ready = !full[0];
    assign s1_ready = !full[1];

    // Writes to x0 complete the handshake but are dropped here.
    assign push[0] = s0_valid && s0_ready && (s0_addr != AW'(REG_ZERO));
    assign push[1] = s1_valid && s1_ready && (s1_addr != AW'(REG_ZERO));

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push        (push[0]),
        .push_addr   (s0_addr),
        .push_data   (s0_data),
        .pop         (grant[0]),
        .full        (full[0]),
        .empty       (empty[0]),
        .count       (count0),
        .head_addr   (head_addr0),
        .head_data   (head_data0),
        .valid_addrs (valid_addrs0)
    );

    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push        (push[1]),
        .push_addr   (s1_addr),
        .push_data   (s1_data),
        .pop         (grant[1]),
        .full        (full[1]),
        .empty       (empty[1]),
        .count       (count1),
        .head_addr   (head_addr1),
        .head_data   (head_data1),
        .valid_addrs (valid_addrs1)
    );

    // On a tie the source that did not win last time is granted.
    assign grant[0] = !empty[0] && (empty[1] || last_grant);
    assign grant[1] = !empty[1] && (empty[0] || !last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            last_grant <= 1'b1;
        end else begin
            rf_we <= |grant;
            if (grant[0]) begin
                rf_wa      <= head_addr0;
                rf_wd      <= head_data0;
                last_grant <= 1'b0;
            end else if (grant[1]) begin
                rf_wa      <= head_addr1;
                rf_wd      <= head_data1;
                last_grant <= 1'b1;
            end
        end
    end

    // The write-stage match covers the cycle where the register file still returns the old value.
    always_comb begin
        logic hit1;
        logic hit2;
        hit1 = rf_we && (rf_wa == ra1);
        hit2 = rf_we && (rf_wa == ra2);
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 || (valid_addrs0[i*AW +: AW] == ra1) || (valid_addrs1[i*AW +: AW] == ra1);
            hit2 = hit2 || (valid_addrs0[i*AW +: AW] == ra2) || (valid_addrs1[i*AW +: AW] == ra2);
        end
        pend1 = (ra1 != AW'(REG_ZERO)) && hit1;
        pend2 = (ra2 != AW'(REG_ZERO)) && hit2;
    end

    assign idle = (count0 == '0) && (count1 == '0) && !rf_we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue,
// a negedge monitor pops and compares every rf_we cycle.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int W = WB_AW + WB_DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s0_valid = 1'b0;
  logic             s0_ready;
  logic [WB_AW-1:0] s0_addr = '0;
  logic [WB_DW-1:0] s0_data = '0;
  logic             s1_valid = 1'b0;
  logic             s1_ready;
  logic [WB_AW-1:0] s1_addr = '0;
  logic [WB_DW-1:0] s1_data = '0;
  logic [WB_AW-1:0] ra1 = '0;
  logic [WB_AW-1:0] ra2 = '0;
  logic             pend1;
  logic             pend2;
  logic             rf_we;
  logic [WB_AW-1:0] rf_wa;
  logic [WB_DW-1:0] rf_wd;
  logic             idle;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  regfile_wb_arbiter #(.DEPTH(2), .AW(WB_AW), .DW(WB_DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_addr  (s0_addr),
    .s0_data  (s0_data),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_addr  (s1_addr),
    .s1_data  (s1_data),
    .ra1      (ra1),
    .ra2      (ra2),
    .pend1    (pend1),
    .pend2    (pend2),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .idle     (idle)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [WB_AW-1:0] a, input logic [WB_DW-1:0] d);
    wb_req_t r;
    r.addr = a;
    r.data = d;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_s0_ready", s0_ready, 1);
    chk("rst_s1_ready", s1_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_pend1", pend1, 0);
    chk("rst_pend2", pend2, 0);
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got write addr=%0d data=%h, expected no write", rf_wa, rf_wd);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rf_wa, rf_wd} !== mon_e) begin
          errors++;
          $display("FAIL wb_order: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_wa, rf_wd, mon_e[W-1 -: WB_AW], mon_e[WB_DW-1:0]);
        end
      end
    end
  end

  initial begin
    int na;
    int nb;

    // reset state
    do_reset();

    // single s0 write, latency and pend window
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd7;
    push_exp(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    s0_valid = 1'b0;
    chk("t2_c1_we", rf_we, 0);
    chk("t2_c1_pend1", pend1, 1);
    chk("t2_c1_pend2", pend2, 0);
    @(negedge clk);
    chk("t2_c2_we", rf_we, 1);
    chk("t2_c2_wa", rf_wa, 5);
    chk("t2_c2_wd", rf_wd, 32'hDEADBEEF);
    chk("t2_c2_pend1", pend1, 1);
    @(negedge clk);
    chk("t2_c3_we", rf_we, 0);
    chk("t2_c3_pend1", pend1, 0);
    chk("t2_c3_idle", idle, 1);

    // ties: first after reset goes to s0, then rotation
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h11;
    s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 32'h22;
    push_exp(5'd1, 32'h11);
    push_exp(5'd2, 32'h22);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    chk("t3_c2_we", rf_we, 1);
    chk("t3_c2_wa", rf_wa, 1);
    @(negedge clk);
    chk("t3_c3_we", rf_we, 1);
    chk("t3_c3_wa", rf_wa, 2);
    @(negedge clk);
    chk("t3_c4_we", rf_we, 0);
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h33;
    push_exp(5'd3, 32'h33);
    @(negedge clk);
    s0_valid = 1'b0;
    @(negedge clk);
    chk("t3_c6_wa", rf_wa, 3);
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd4; s0_data = 32'h44;
    s1_valid = 1'b1; s1_addr = 5'd6; s1_data = 32'h66;
    push_exp(5'd6, 32'h66);
    push_exp(5'd4, 32'h44);
    @(negedge clk);
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    chk("t3_tie2_first_wa", rf_wa, 6);
    @(negedge clk);
    chk("t3_tie2_second_wa", rf_wa, 4);
    @(negedge clk);
    chk("t3_idle", idle, 1);

    // both sources streaming for 20 cycles
    do_reset();
    na = 0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 2) chk($sformatf("t4_we_c%0d", c), rf_we, 1);
      chk($sformatf("t4_s0_ready_c%0d", c), s0_ready, (c < 2 || c % 2 == 0) ? 1 : 0);
      chk($sformatf("t4_s1_ready_c%0d", c), s1_ready, (c < 2 || c % 2 == 1) ? 1 : 0);
      s0_valid = 1'b1; s0_addr = 5'(16 + na % 8); s0_data = 32'hA000_0000 + 32'(na);
      s1_valid = 1'b1; s1_addr = 5'(24 + nb % 7); s1_data = 32'hB000_0000 + 32'(nb);
      if (s0_ready) begin
        push_exp(s0_addr, s0_data);
        na++;
      end
      if (s1_ready) begin
        push_exp(s1_addr, s1_data);
        nb++;
      end
    end
    for (int c = 20; c < 24; c++) begin
      @(negedge clk);
      s0_valid = 1'b0; s1_valid = 1'b0;
      chk($sformatf("t4_drain_we_c%0d", c), rf_we, 1);
    end
    @(negedge clk);
    chk("t4_end_we", rf_we, 0);
    chk("t4_end_idle", idle, 1);
    chk("t4_s0_accepts", na, 11);
    chk("t4_s1_accepts", nb, 11);

    // write to x0 is accepted and dropped
    @(negedge clk);
    s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'hFFFF; ra1 = 5'd0;
    @(negedge clk);
    s1_valid = 1'b0;
    chk("t5_s1_ready", s1_ready, 1);
    chk("t5_pend1", pend1, 0);
    chk("t5_idle", idle, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t5_we", rf_we, 0);
    end

    // reset while writes are queued
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 5'd10; s0_data = 32'hA;
    s1_valid = 1'b1; s1_addr = 5'd11; s1_data = 32'hB;
    ra2 = 5'd12;
    push_exp(5'd10, 32'hA);
    @(negedge clk);
    s0_addr = 5'd12; s0_data = 32'hC;
    s1_valid = 1'b0;
    @(negedge clk);
    s0_valid = 1'b0;
    chk("t6_c2_we", rf_we, 1);
    chk("t6_c2_wa", rf_wa, 10);
    chk("t6_c2_pend2", pend2, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_c3_we", rf_we, 0);
    chk("t6_c3_idle", idle, 1);
    chk("t6_c3_pend2", pend2, 0);
    chk("t6_c3_s0_ready", s0_ready, 1);
    repeat (5) begin
      @(negedge clk);
      chk("t6_after_we", rf_we, 0);
    end

    chk("exp_q_empty", exp_q.size(), 0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
